// File: rtl/mm_tile_scheduler.sv
// mm_tile_scheduler: walks a K x N grid of matrix-mult tile jobs, issuing one engine start per
// job with its buffer offsets, with abort/drain handling.
module mm_tile_scheduler #(
    parameter int ROW    = 4,
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256,
    parameter int AW     = $clog2(256)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [3:0]    cmd_k_m1_i,
    input  logic [3:0]    cmd_n_m1_i,
    input  logic [AW-1:0] cmd_i_rows_i,
    input  logic [AW-1:0] cmd_w_base_i,
    input  logic [AW-1:0] cmd_i_base_i,
    input  logic [AW-1:0] cmd_o_base_i,
    input  logic          abort_i,
    output logic          mm_start_o,
    output logic [AW-1:0] mm_w_offset_o,
    output logic [AW-1:0] mm_i_offset_o,
    output logic [AW-1:0] mm_psum_offset_o,
    output logic [AW-1:0] mm_o_offset_o,
    output logic          mm_accum_en_o,
    input  logic          mm_done_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          aborted_o
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_k_m1, r_n_m1, r_k, r_n;
    logic [AW-1:0] r_rows, r_i_base, r_w_ptr, r_i_ptr, r_o_ptr;
    logic          r_aborted;
    logic          w_accept, w_last_k, w_last_n, w_step, w_abort_end;

    if (W_SIZE > 2**AW || I_SIZE > 2**AW || O_SIZE > 2**AW) begin : g_size_check
        $error("buffer depth exceeds address range");
    end

    assign w_accept    = cmd_valid_i && r_state == S_IDLE;
    assign w_last_k    = r_k == r_k_m1;
    assign w_last_n    = r_n == r_n_m1;
    assign w_step      = r_state == S_WAIT && mm_done_i && !abort_i && !(w_last_k && w_last_n);
    assign w_abort_end = mm_done_i && ((r_state == S_WAIT && abort_i) || r_state == S_DRAIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = cmd_valid_i ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = abort_i ? S_DRAIN : S_WAIT;
            S_WAIT:  w_next = mm_done_i ? (abort_i ? S_IDLE : (w_last_k && w_last_n) ? S_DONE : S_ISSUE)
                                        : (abort_i ? S_DRAIN : S_WAIT);
            S_DRAIN: w_next = mm_done_i ? S_IDLE : S_DRAIN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_k_m1    <= '0;
            r_n_m1    <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_rows    <= '0;
            r_i_base  <= '0;
            r_w_ptr   <= '0;
            r_i_ptr   <= '0;
            r_o_ptr   <= '0;
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_k_m1    <= cmd_k_m1_i;
            r_n_m1    <= cmd_n_m1_i;
            r_k       <= '0;
            r_n       <= '0;
            r_rows    <= cmd_i_rows_i;
            r_i_base  <= cmd_i_base_i;
            r_w_ptr   <= cmd_w_base_i;
            r_i_ptr   <= cmd_i_base_i;
            r_o_ptr   <= cmd_o_base_i;
            r_aborted <= 1'b0;
        end else begin
            // Weights advance every job; inputs rewind and outputs advance at each new column tile.
            if (w_step) begin
                r_k     <= w_last_k ? 4'd0 : r_k + 4'd1;
                r_n     <= w_last_k ? r_n + 4'd1 : r_n;
                r_w_ptr <= r_w_ptr + AW'(ROW);
                r_i_ptr <= w_last_k ? r_i_base : r_i_ptr + r_rows;
                r_o_ptr <= w_last_k ? r_o_ptr + r_rows : r_o_ptr;
            end
            if (w_abort_end) r_aborted <= 1'b1;
        end
    end

    assign cmd_ready_o      = r_state == S_IDLE;
    assign mm_start_o       = r_state == S_ISSUE;
    assign mm_w_offset_o    = r_w_ptr;
    assign mm_i_offset_o    = r_i_ptr;
    assign mm_psum_offset_o = r_o_ptr;
    assign mm_o_offset_o    = r_o_ptr;
    assign mm_accum_en_o    = r_k != 4'd0;
    assign busy_o           = r_state != S_IDLE;
    assign done_o           = r_state == S_DONE;
    assign aborted_o        = r_aborted;
endmodule

// File: tb/tb_mm_tile_scheduler.sv
// tb_mm_tile_scheduler: randomized command/engine driver with a job scoreboard; a negedge
// monitor checks every start pulse against offsets computed from the tiling rules.
module tb_mm_tile_scheduler;
    localparam int ROW = 4;
    localparam int AW  = 8;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] i;
        logic [7:0] o;
        logic       acc;
    } job_t;

    typedef struct {
        int         km;
        int         nm;
        logic [7:0] rows;
        logic [7:0] wb;
        logic [7:0] ib;
        logic [7:0] ob;
    } cmd_t;

    logic          clk_i = 1'b0, rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0, abort_i = 1'b0, mm_done_i = 1'b0;
    logic [3:0]    cmd_k_m1_i = '0, cmd_n_m1_i = '0;
    logic [AW-1:0] cmd_i_rows_i = '0, cmd_w_base_i = '0, cmd_i_base_i = '0, cmd_o_base_i = '0;
    logic          cmd_ready_o, mm_start_o, mm_accum_en_o, busy_o, done_o, aborted_o;
    logic [AW-1:0] mm_w_offset_o, mm_i_offset_o, mm_psum_offset_o, mm_o_offset_o;

    int   total = 0, bad = 0, n_done = 0, exp_done = 0;
    job_t exp_q[$];
    job_t e;

    mm_tile_scheduler #(.ROW(ROW), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_k_m1_i(cmd_k_m1_i), .cmd_n_m1_i(cmd_n_m1_i), .cmd_i_rows_i(cmd_i_rows_i),
        .cmd_w_base_i(cmd_w_base_i), .cmd_i_base_i(cmd_i_base_i), .cmd_o_base_i(cmd_o_base_i),
        .abort_i(abort_i), .mm_start_o(mm_start_o),
        .mm_w_offset_o(mm_w_offset_o), .mm_i_offset_o(mm_i_offset_o),
        .mm_psum_offset_o(mm_psum_offset_o), .mm_o_offset_o(mm_o_offset_o),
        .mm_accum_en_o(mm_accum_en_o), .mm_done_i(mm_done_i),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_start"}, mm_start_o, 0);
        chk({nm, "_woff"}, mm_w_offset_o, 0);
        chk({nm, "_ioff"}, mm_i_offset_o, 0);
        chk({nm, "_poff"}, mm_psum_offset_o, 0);
        chk({nm, "_ooff"}, mm_o_offset_o, 0);
        chk({nm, "_acc"}, mm_accum_en_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_done"}, done_o, 0);
        chk({nm, "_aborted"}, aborted_o, 0);
        chk({nm, "_ready"}, cmd_ready_o, 1);
    endtask

    // Monitor: every start pulse must match the next expected job.
    initial forever begin
        @(negedge clk_i);
        if (mm_start_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_start: got start w=%0h i=%0h, expected no start", mm_w_offset_o, mm_i_offset_o);
            end else begin
                e = exp_q.pop_front();
                chk("w_off", mm_w_offset_o, e.w);
                chk("i_off", mm_i_offset_o, e.i);
                chk("psum_off", mm_psum_offset_o, e.o);
                chk("o_off", mm_o_offset_o, e.o);
                chk("accum_en", mm_accum_en_o, e.acc);
            end
        end
        if (done_o) n_done++;
    end

    // mode: 0 normal, 1 abort in WAIT then done 5 cycles later, 2 abort+done together,
    // 3 abort in ISSUE, 4 reset in WAIT. stop = job index where the event happens.
    task automatic run_cmd(input cmd_t c, input int mode, input int stop, input bit hold, input cmd_t nxt);
        int K = c.km + 1;
        int N = c.nm + 1;
        int last = (mode == 0) ? K * N - 1 : stop;
        job_t j_exp;
        for (int j = 0; j <= last; j++) begin
            j_exp.w   = 8'(int'(c.wb) + ROW * j);
            j_exp.i   = 8'(int'(c.ib) + (j % K) * int'(c.rows));
            j_exp.o   = 8'(int'(c.ob) + (j / K) * int'(c.rows));
            j_exp.acc = (j % K) != 0;
            exp_q.push_back(j_exp);
        end
        if (mode == 0) exp_done++;
        cmd_k_m1_i = 4'(c.km); cmd_n_m1_i = 4'(c.nm); cmd_i_rows_i = c.rows;
        cmd_w_base_i = c.wb; cmd_i_base_i = c.ib; cmd_o_base_i = c.ob;
        cmd_valid_i = 1'b1;
        for (int t = 0; t < 50 && !cmd_ready_o; t++) tick();
        chk("ready_wait", cmd_ready_o, 1);
        tick();
        if (hold) begin
            cmd_k_m1_i = 4'(nxt.km); cmd_n_m1_i = 4'(nxt.nm); cmd_i_rows_i = nxt.rows;
            cmd_w_base_i = nxt.wb; cmd_i_base_i = nxt.ib; cmd_o_base_i = nxt.ob;
        end else cmd_valid_i = 1'b0;
        chk("accept_start_lat", mm_start_o, 1);
        chk("busy_no_ready", cmd_ready_o, 0);
        chk("aborted_cleared", aborted_o, 0);
        for (int j = 0; j <= last; j++) begin
            if (mode == 3 && j == stop) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                chk("issue_abort_nostart", mm_start_o, 0);
                chk("issue_abort_busy", busy_o, 1);
                repeat (3) tick();
                mm_done_i = 1'b1;
                tick();
                mm_done_i = 1'b0;
                chk("issue_abort_flag", aborted_o, 1);
                chk("issue_abort_ready", cmd_ready_o, 1);
                return;
            end
            tick();
            if (mode == 1 && j == stop) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                for (int d = 0; d < 5; d++) begin
                    chk("drain_busy", busy_o, 1);
                    chk("drain_aborted_low", aborted_o, 0);
                    tick();
                end
                mm_done_i = 1'b1;
                tick();
                mm_done_i = 1'b0;
                chk("drain_aborted", aborted_o, 1);
                chk("drain_ready", cmd_ready_o, 1);
                chk("drain_idle", busy_o, 0);
                return;
            end
            if (mode == 2 && j == stop) begin
                abort_i = 1'b1;
                mm_done_i = 1'b1;
                tick();
                abort_i = 1'b0;
                mm_done_i = 1'b0;
                chk("abort_done_aborted", aborted_o, 1);
                chk("abort_done_ready", cmd_ready_o, 1);
                chk("abort_done_nodone", done_o, 0);
                return;
            end
            if (mode == 4 && j == stop) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                chk_reset_outputs("wait_reset");
                return;
            end
            repeat ($urandom_range(0, 3)) tick();
            mm_done_i = 1'b1;
            tick();
            mm_done_i = 1'b0;
            if (j == last) begin
                chk("done_lat", done_o, 1);
                tick();
                chk("done_pulse_one", done_o, 0);
                chk("end_ready", cmd_ready_o, 1);
            end else chk("next_start_lat", mm_start_o, 1);
        end
    endtask

    initial begin
        cmd_t c, b, z;
        int md, kn;
        z = '{0, 0, 8'h0, 8'h0, 8'h0, 8'h0};
        repeat (3) tick();
        rst_i = 1'b0;
        chk_reset_outputs("reset");
        mm_done_i = 1'b1;
        tick();
        mm_done_i = 1'b0;
        chk("idle_done_busy", busy_o, 0);
        chk("idle_done_start", mm_start_o, 0);
        chk("idle_done_ready", cmd_ready_o, 1);
        run_cmd('{0, 0, 8'd8, 8'h10, 8'h20, 8'h30}, 0, 0, 1'b0, z);
        run_cmd('{2, 1, 8'd8, 8'h00, 8'h40, 8'h80}, 0, 0, 1'b0, z);
        run_cmd('{1, 0, 8'd4, 8'hFC, 8'h00, 8'h00}, 0, 0, 1'b0, z);
        b = '{1, 1, 8'd3, 8'h11, 8'h22, 8'h33};
        run_cmd('{2, 0, 8'd5, 8'hA0, 8'hB0, 8'hC0}, 0, 0, 1'b1, b);
        run_cmd(b, 0, 0, 1'b0, z);
        run_cmd('{2, 1, 8'd8, 8'h00, 8'h40, 8'h80}, 1, 2, 1'b0, z);
        run_cmd('{1, 1, 8'd8, 8'h08, 8'h40, 8'h80}, 2, 1, 1'b0, z);
        run_cmd('{1, 1, 8'd8, 8'h08, 8'h40, 8'h80}, 3, 0, 1'b0, z);
        run_cmd('{3, 2, 8'd16, 8'h50, 8'h60, 8'h70}, 4, 3, 1'b0, z);
        run_cmd('{1, 1, 8'd8, 8'hF8, 8'hF0, 8'hE0}, 0, 0, 1'b0, z);
        for (int r = 0; r < 14; r++) begin
            c.km = $urandom_range(0, 15);
            c.nm = (r % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            c.rows = 8'($urandom);
            c.wb = 8'($urandom);
            c.ib = 8'($urandom);
            c.ob = 8'($urandom);
            kn = (c.km + 1) * (c.nm + 1);
            md = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_cmd(c, md, $urandom_range(0, kn - 1), 1'b0, z);
        end
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", n_done, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mm_tile_scheduler.md
MM_TILE_SCHEDULER -- requirements
Module: mm_tile_scheduler

Interface
REQ-001 Parameters SHALL be: ROW, default 4, systolic array rows and weight-tile height; W_SIZE, I_SIZE and O_SIZE, default 256 each, buffer depths; AW, default $clog2(256)=8, address width.
REQ-002 clk_i  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 cmd_valid_i  in  1 / cmd_ready_o  out  1  command handshake; a command is accepted on the edge where both are 1.
REQ-005 cmd_k_m1_i  in  4  number of reduction tiles minus 1 (K = value+1, range 1..16).
REQ-006 cmd_n_m1_i  in  4  number of output column tiles minus 1 (N = value+1, range 1..16).
REQ-007 cmd_i_rows_i  in  AW  input rows per tile.
REQ-008 cmd_w_base_i, cmd_i_base_i, cmd_o_base_i  in  AW each  base addresses of the weight, input and output buffers.
REQ-009 abort_i  in  1  abort request.
REQ-010 mm_start_o  out  1  one-cycle start pulse to the matrix-mult engine.
REQ-011 mm_w_offset_o, mm_i_offset_o, mm_psum_offset_o, mm_o_offset_o  out  AW each  per-job address offsets.
REQ-012 mm_accum_en_o  out  1  per-job accumulate enable.
REQ-013 mm_done_i  in  1  engine job-complete pulse.
REQ-014 busy_o  out  1  high whenever the state is not IDLE.
REQ-015 done_o  out  1  one-cycle command-complete pulse.
REQ-016 aborted_o  out  1  sticky status flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, DRAIN and DONE.
REQ-018 cmd_ready_o SHALL be 1 only in IDLE; on accept the block latches K, N, i_rows and the bases, sets k=0, n=0, w_ptr=w_base, i_ptr=i_base, o_ptr=o_base, clears aborted_o, and goes to ISSUE.
REQ-019 In ISSUE, mm_start_o SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-020 The outputs mm_w_offset_o=w_ptr, mm_i_offset_o=i_ptr, mm_psum_offset_o=mm_o_offset_o=o_ptr and mm_accum_en_o=(k!=0) SHALL be valid in ISSUE and held stable through WAIT.
REQ-021 In WAIT, on mm_done_i with k==K-1 and n==N-1, the next state SHALL be DONE.
REQ-022 In WAIT, on mm_done_i with k<K-1, the block SHALL set k+=1, w_ptr+=ROW and i_ptr+=i_rows, then go to ISSUE.
REQ-023 In WAIT, on mm_done_i with k==K-1 and n<N-1, the block SHALL set k=0, n+=1, w_ptr+=ROW, i_ptr=i_base and o_ptr+=i_rows, then go to ISSUE.
REQ-024 All pointer arithmetic SHALL be modulo 2^AW, wrapping silently with no error flag.
REQ-025 Latency SHALL be: one cycle from accept to the first mm_start_o; one cycle from mm_done_i to the next mm_start_o; one cycle from the final mm_done_i to done_o.
REQ-026 The total number of start pulses per command SHALL be K*N.
REQ-027 mm_done_i SHALL be ignored in IDLE, ISSUE and DONE.
REQ-028 In DONE, done_o SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-029 abort_i in ISSUE SHALL still emit that cycle's mm_start_o and SHALL then go to DRAIN.
REQ-030 abort_i in WAIT without mm_done_i SHALL go to DRAIN.
REQ-031 abort_i and mm_done_i together in WAIT SHALL go directly to IDLE with aborted_o=1.
REQ-032 DRAIN SHALL wait for mm_done_i, then go to IDLE and set aborted_o=1; done_o SHALL NOT be asserted for an aborted command.
REQ-033 abort_i SHALL be ignored in IDLE, DRAIN and DONE.
REQ-034 A new command SHALL NOT be accepted until the state is IDLE, and command inputs SHALL be sampled only on accept.

Reset
REQ-035 rst_i=1 SHALL force, on the next edge, state=IDLE, all counters and pointers to 0, mm_start_o=0, mm_accum_en_o=0, all offsets=0, busy_o=0, done_o=0, aborted_o=0, and cmd_ready_o=1 after release.
REQ-036 Reset SHALL take priority over every other input, including reset in the middle of WAIT with no mm_done_i issued.

Verification
REQ-037 Single tile: K_m1=0, N_m1=0, bases 0x10/0x20/0x30 -> one start with offsets 0x10/0x20/0x30/0x30 and accum_en=0; done_o one cycle after mm_done_i.
REQ-038 K=3, N=2, i_rows=8, w_base=0, i_base=0x40, o_base=0x80 -> 6 starts with w_offset 0,4,8,12,16,20; i_offset 0x40,0x48,0x50,0x40,0x48,0x50; o_offset 0x80 x3 then 0x88 x3; accum_en 0,1,1,0,1,1.
REQ-039 Wrap: w_base=0xFC, K=2 -> w_offset sequence is 0xFC then 0x00.
REQ-040 Abort in WAIT, mm_done_i 5 cycles later -> no further start, busy_o stays 1 until mm_done_i, then aborted_o=1, done_o never asserted, cmd_ready_o=1.
REQ-041 cmd_valid_i held high during a busy command -> not accepted until IDLE; a spurious mm_done_i in IDLE has no effect.
REQ-042 rst_i asserted in WAIT -> all outputs at reset values next cycle; a fresh command afterward runs correctly.
